// File: rtl/jtopl_wrarb_pkg.sv
// Shared types and defaults for the jtopl write sequencer / arbiter.
package jtopl_wrarb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_WR,
        ST_ADDR_WAIT,
        ST_DATA_WR,
        ST_DATA_WAIT
    } state_t;

    localparam int ADDR_WAIT_DEF = 12;
    localparam int DATA_WAIT_DEF = 84;

    // One latched register write
    typedef struct packed {
        logic [7:0] regn;
        logic [7:0] val;
    } wr_t;

endpackage

// File: rtl/jtopl_wrarb_timer.sv
// cen-qualified down-counter. A load of 0 is taken as 1 so a wait always
// lasts at least one cen tick; the count stops at 0 instead of wrapping.
module jtopl_wrarb_timer #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expire
);

    logic [CW-1:0] cnt;

    // load has priority; otherwise count down on cen, holding at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= (load_val == '0) ? CW'(1) : load_val;
        else if (cen && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // last tick of the wait: count at one and a cen arriving
    assign expire = cen && (cnt == CW'(1));

endmodule

// File: rtl/jtopl_wrarb.sv
// Two-port round-robin write arbiter and address/data strobe sequencer
// in front of the jtopl CPU bus. Optional macro JTOPL_WRARB_SHADOW_EN
// adds a 256x8 shadow copy of every register written.
module jtopl_wrarb
    import jtopl_wrarb_pkg::*;
#(
    parameter int ADDR_WAIT = ADDR_WAIT_DEF,
    parameter int DATA_WAIT = DATA_WAIT_DEF,
    parameter int CW        = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_reg,
    input  logic [7:0] req0_val,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_reg,
    input  logic [7:0] req1_val,
    output logic       opl_cs_n,
    output logic       opl_wr_n,
    output logic       opl_addr,
    output logic [7:0] opl_din,
    output logic       busy,
    output logic       gnt_id
`ifdef JTOPL_WRARB_SHADOW_EN
    ,
    input  logic [7:0] shadow_addr,
    output logic [7:0] shadow_dout
`endif
);

    state_t        state;
    wr_t           wr_q;
    logic          grant;
    logic          idle_ok;
    logic          xfer;
    logic          busy_q;
    logic          clr_busy;
    logic          t_load;
    logic [CW-1:0] t_val;
    logic          t_exp;

    // requester 1 wins when alone or when requester 0 owned the bus last
    assign grant      = req1_valid && (!req0_valid || !gnt_id);
    assign idle_ok    = rst_n && !clr_busy && (state == ST_IDLE);
    assign req0_ready = idle_ok && !grant;
    assign req1_ready = idle_ok && grant;
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // the wait starts on the cen that ends a strobe state
    assign t_load = cen && (state == ST_ADDR_WR || state == ST_DATA_WR);
    assign t_val  = (state == ST_ADDR_WR) ? CW'(ADDR_WAIT) : CW'(DATA_WAIT);

    jtopl_wrarb_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .load     (t_load),
        .load_val (t_val),
        .expire   (t_exp)
    );

    // sequencer; pin outputs are set alongside the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_q     <= '0;
            gnt_id   <= 1'b1;
            busy_q   <= 1'b0;
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            opl_addr <= 1'b0;
            opl_din  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: if (xfer) begin
                    wr_q     <= grant ? {req1_reg, req1_val} : {req0_reg, req0_val};
                    gnt_id   <= grant;
                    busy_q   <= 1'b1;
                    opl_cs_n <= 1'b0;
                    opl_wr_n <= 1'b0;
                    opl_addr <= 1'b0;
                    opl_din  <= grant ? req1_reg : req0_reg;
                    state    <= ST_ADDR_WR;
                end
                ST_ADDR_WR: if (cen) begin
                    opl_cs_n <= 1'b1;
                    opl_wr_n <= 1'b1;
                    state    <= ST_ADDR_WAIT;
                end
                ST_ADDR_WAIT: if (t_exp) begin
                    opl_cs_n <= 1'b0;
                    opl_wr_n <= 1'b0;
                    opl_addr <= 1'b1;
                    opl_din  <= wr_q.val;
                    state    <= ST_DATA_WR;
                end
                ST_DATA_WR: if (cen) begin
                    opl_cs_n <= 1'b1;
                    opl_wr_n <= 1'b1;
                    state    <= ST_DATA_WAIT;
                end
                ST_DATA_WAIT: if (t_exp) begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q || clr_busy;

`ifdef JTOPL_WRARB_SHADOW_EN
    logic [7:0] shadow_mem [256];
    logic [8:0] clr_idx;
    logic       sh_we;

    // bit 8 of the index marks the post-reset clear as finished
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clr_idx <= 9'd0;
        else if (!clr_idx[8])
            clr_idx <= clr_idx + 9'd1;
    end

    assign clr_busy = !clr_idx[8];
    assign sh_we    = (state == ST_ADDR_WAIT) && t_exp;

    // shadow write on entry to the data strobe, registered read port
    always_ff @(posedge clk) begin
        if (clr_busy)
            shadow_mem[clr_idx[7:0]] <= 8'd0;
        else if (sh_we)
            shadow_mem[wr_q.regn] <= wr_q.val;
        shadow_dout <= shadow_mem[shadow_addr];
    end
`else
    assign clr_busy = 1'b0;
`endif

endmodule

// File: tb/tb_jtopl_wrarb.sv
// Directed bench for jtopl_wrarb: reset state, single write timing,
// cen/4 stretching, reset mid-wait, round-robin tie, withdrawn valid,
// and the shadow file when JTOPL_WRARB_SHADOW_EN is defined.
module tb_jtopl_wrarb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_reg, req0_val, req1_reg, req1_val;
    logic       opl_cs_n, opl_wr_n, opl_addr;
    logic [7:0] opl_din;
    logic       busy, gnt_id;
`ifdef JTOPL_WRARB_SHADOW_EN
    logic [7:0] shadow_addr;
    logic [7:0] shadow_dout;
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    jtopl_wrarb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_reg   (req0_reg),
        .req0_val   (req0_val),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_reg   (req1_reg),
        .req1_val   (req1_val),
        .opl_cs_n   (opl_cs_n),
        .opl_wr_n   (opl_wr_n),
        .opl_addr   (opl_addr),
        .opl_din    (opl_din),
        .busy       (busy),
        .gnt_id     (gnt_id)
`ifdef JTOPL_WRARB_SHADOW_EN
        ,
        .shadow_addr (shadow_addr),
        .shadow_dout (shadow_dout)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // cen generator: updated 2 ns after each edge, so at the falling edge
    // cen shows the value the next rising edge will use
    logic cen_div4 = 1'b0;
    int   cdiv     = 0;
    initial begin
        cen = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            cdiv++;
            cen = !cen_div4 || (cdiv % 4 == 0);
        end
    end

    // monitor: strobe log, handshake log, busy fall, req1_ready count
    int   cyc = 0;
    int   nst = 0, nhs = 0;
    int   st_start [64];
    int   st_len   [64];
    logic st_addr  [64];
    logic [7:0] st_din [64];
    logic st_cov   [64];
    logic st_wr    [64];
    logic hs_id    [64];
    int   hs_cyc   [64];
    int   busy_fall = 0;
    int   r1_rdy_cnt = 0;
    logic prev_cs = 1'b1, prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!opl_cs_n) begin
            if (prev_cs) begin
                st_start[nst] <= cyc;
                st_len[nst]   <= 1;
                st_addr[nst]  <= opl_addr;
                st_din[nst]   <= opl_din;
                st_cov[nst]   <= cen;
                st_wr[nst]    <= !opl_wr_n;
                nst           <= nst + 1;
            end else begin
                st_len[nst-1] <= st_len[nst-1] + 1;
                st_cov[nst-1] <= st_cov[nst-1] | cen;
                st_wr[nst-1]  <= st_wr[nst-1] & !opl_wr_n;
            end
        end
        prev_cs <= opl_cs_n;
        if (req0_valid && req0_ready) begin
            hs_id[nhs]  <= 1'b0;
            hs_cyc[nhs] <= cyc;
            nhs         <= nhs + 1;
        end else if (req1_valid && req1_ready) begin
            hs_id[nhs]  <= 1'b1;
            hs_cyc[nhs] <= cyc;
            nhs         <= nhs + 1;
        end
        if (prev_busy && !busy) busy_fall <= cyc;
        prev_busy <= busy;
        if (req1_ready) r1_rdy_cnt <= r1_rdy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 400 && busy; n++) begin
            @(posedge clk);
            #1;
        end
        check("idle_wait", busy, 0);
    endtask

    // present one write and hold it until accepted; called 1 ns after an edge
    task automatic send(input bit id, input logic [7:0] r, input logic [7:0] v);
        bit ok = 1'b0;
        if (id == 1'b0) begin req0_valid = 1'b1; req0_reg = r; req0_val = v; end
        else            begin req1_valid = 1'b1; req1_reg = r; req1_val = v; end
        for (int n = 0; n < 3000 && !ok; n++) begin
            #2;
            if ((id == 1'b0) ? req0_ready : req1_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
        check("send_accepted", ok, 1);
    endtask

    logic [7:0] tie_reg [6] = '{8'h10, 8'h18, 8'h11, 8'h19, 8'h12, 8'h1A};
    logic [7:0] tie_val [6] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};

    initial begin
        int a0, acc, h0, hh, r1c, mg, g;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_reg = 8'h00; req0_val = 8'h00;
        req1_valid = 1'b1; req1_reg = 8'h00; req1_val = 8'h00;
`ifdef JTOPL_WRARB_SHADOW_EN
        shadow_addr = 8'h00;
`endif
        wait_cyc(3);

        // reset state, with both valids raised to exercise ready gating
        check("rst_cs_n", opl_cs_n, 1);
        check("rst_wr_n", opl_wr_n, 1);
        check("rst_addr", opl_addr, 0);
        check("rst_din", opl_din, 0);
        check("rst_busy", busy, BUSY_RST);
        check("rst_gnt_id", gnt_id, 1);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        wait_idle();

        // single write, cen=1
        a0 = nst;
        send(0, 8'h20, 8'h01);
        acc = hs_cyc[nhs-1];
        wait_cyc(110);
        check("a_nstrobes", nst - a0, 2);
        check("a_addr_start", st_start[a0], acc + 1);
        check("a_addr_len", st_len[a0], 1);
        check("a_addr_port", st_addr[a0], 0);
        check("a_addr_din", st_din[a0], 8'h20);
        check("a_addr_wr", st_wr[a0], 1);
        check("a_data_start", st_start[a0+1], acc + 14);
        check("a_data_len", st_len[a0+1], 1);
        check("a_data_port", st_addr[a0+1], 1);
        check("a_data_din", st_din[a0+1], 8'h01);
        check("a_busy_fall", busy_fall, acc + 99);
        check("a_gnt_id", gnt_id, 0);

        // cen high one clock in four
        cen_div4 = 1'b1;
        a0 = nst;
        send(0, 8'h40, 8'h3F);
        wait_cyc(450);
        check("b_nstrobes", nst - a0, 2);
        check("b_addr_len_range", (st_len[a0] >= 1) && (st_len[a0] <= 4), 1);
        check("b_addr_cov", st_cov[a0], 1);
        check("b_addr_din", st_din[a0], 8'h40);
        check("b_addr_gap", st_start[a0+1] - (st_start[a0] + st_len[a0]), 48);
        check("b_data_len", st_len[a0+1], 4);
        check("b_data_cov", st_cov[a0+1], 1);
        check("b_data_din", st_din[a0+1], 8'h3F);
        check("b_busy_fall", busy_fall, st_start[a0+1] + 340);
        cen_div4 = 1'b0;
        wait_cyc(2);

        // reset asserted during DATA_WAIT
        a0 = nst;
        send(0, 8'h60, 8'h55);
        wait_cyc(30);
        check("c_busy_pre", busy, 1);
        check("c_addr_pre", opl_addr, 1);
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("c_cs_n", opl_cs_n, 1);
        check("c_busy", busy, BUSY_RST);
        check("c_addr", opl_addr, 0);
        check("c_din", opl_din, 0);
        check("c_gnt_id", gnt_id, 1);
        check("c_ready0", req0_ready, 0);
        check("c_ready1", req1_ready, 0);
        wait_cyc(3);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        wait_cyc(2);
        check("c_no_strobe", nst - a0, 2);
        wait_idle();

        // tie from reset, three writes per requester
        h0 = nhs;
        a0 = nst;
        fork
            begin
                for (int i = 0; i < 3; i++) send(0, tie_reg[2*i], tie_val[2*i]);
            end
            begin
                for (int i = 0; i < 3; i++) send(1, tie_reg[2*i+1], tie_val[2*i+1]);
            end
        join
        wait_cyc(110);
        check("t_nstrobes", nst - a0, 12);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t_grant%0d", k), hs_id[h0+k], k % 2);
            check($sformatf("t_reg%0d", k), st_din[a0+2*k], tie_reg[k]);
            check($sformatf("t_val%0d", k), st_din[a0+2*k+1], tie_val[k]);
        end
        mg = 1000;
        for (int k = 0; k < 11; k++) begin
            g = st_start[a0+k+1] - (st_start[a0+k] + st_len[a0+k]);
            if (g < mg) mg = g;
        end
        check("t_min_gap_ge12", mg >= 12, 1);

        // requester 1 pulses valid while ADDR_WAIT runs
        a0 = nst;
        hh = nhs;
        r1c = r1_rdy_cnt;
        send(0, 8'h30, 8'h07);
        wait_cyc(3);
        req1_valid = 1'b1; req1_reg = 8'h99; req1_val = 8'h99;
        wait_cyc(1);
        req1_valid = 1'b0;
        wait_cyc(110);
        check("d_nstrobes", nst - a0, 2);
        check("d_handshakes", nhs - hh, 1);
        check("d_ready1_never", r1_rdy_cnt - r1c, 0);
        check("d_data_din", st_din[a0+1], 8'h07);

`ifdef JTOPL_WRARB_SHADOW_EN
        send(0, 8'hBD, 8'h20);
        wait_cyc(110);
        shadow_addr = 8'hBD;
        wait_cyc(1);
        check("s_shadow_bd", shadow_dout, 8'h20);
        shadow_addr = 8'h05;
        wait_cyc(1);
        check("s_shadow_clear", shadow_dout, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
